// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RISC-V multi-cycle sequencer:
// FSM state encoding, major opcode constants and the EBREAK word.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [6:0] OP_NONE   = 7'b0000000;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/pc_unit.sv
// Program counter with a latched next-PC (branch target or PC+1, wrapping).
// Ports: clk, rst, latch_i (capture next PC), load_i (commit next PC),
//        br_taken/br_target (branch decision), pc (current PC).
module pc_unit #(
  parameter int ADDR_W   = 7,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              latch_i,
  input  logic              load_i,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;

  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (latch_i)
      npc_d = br_taken ? br_target : pc_q + ADDR_W'(1);
    if (load_i)
      pc_d = npc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_PC);
      npc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch over req/ack, hold IR, stall on data memory,
// gate rf/dmem writes to once per instruction, count retired instructions.
// Ports: clk, rst, run; imem_req/addr/ack/rdata; instr, addr_mem to decoder;
//        opcode, dec_RW, dec_MW, br_taken, br_target from decoder/ALU;
//        dmem_req/we/ack; rf_we; halt; instret.
module core_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr_mem,
  input  logic [6:0]        opcode,
  input  logic              dec_RW,
  input  logic              dec_MW,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic              halt,
  output logic [CNT_W-1:0]  instret
);

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              halt_q, halt_d;
  logic [ADDR_W-1:0] pc;

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .latch_i   (state_q == S_EXEC),
    .load_i    (state_q == S_WB),
    .br_taken  (br_taken),
    .br_target (br_target),
    .pc        (pc)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    addr_d    = addr_q;
    instret_d = instret_q;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          addr_d  = pc;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (opcode == OP_NONE || ir_q == EBREAK)
          state_d = S_HALT;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM:   if (dmem_ack) state_d = S_WB;
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // Registered strobes follow the state being entered.
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM);
    halt_d     = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      addr_q     <= ADDR_W'(RESET_PC);
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      addr_q     <= addr_d;
      instret_q  <= instret_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      halt_q     <= halt_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc;
  assign instr     = ir_q;
  assign addr_mem  = addr_q;
  assign dmem_req  = dmem_req_q;
  assign halt      = halt_q;
  assign instret   = instret_q;
  // Write strobes are state-decoded so they cannot leak outside WB / MEM.
  assign rf_we     = (state_q == S_WB)  & dec_RW;
  assign dmem_we   = (state_q == S_MEM) & dec_MW;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
// Acts as a minimal decoder: opcode from IR, RW/MW from opcode.
module tb_core_sequencer;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [6:0]  addr_mem;
  logic [6:0]  opcode;
  logic        dec_RW;
  logic        dec_MW;
  logic        br_taken = 1'b0;
  logic [6:0]  br_target = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        rf_we;
  logic        halt;
  logic [15:0] instret;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign opcode = instr[6:0];
  assign dec_MW = (opcode == OP_STORE);
  assign dec_RW = !(opcode == OP_STORE || opcode == OP_BRANCH ||
                    opcode == OP_SYSTEM || opcode == OP_NONE);

  core_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .addr_mem   (addr_mem),
    .opcode     (opcode),
    .dec_RW     (dec_RW),
    .dec_MW     (dec_MW),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .rf_we      (rf_we),
    .halt       (halt),
    .instret    (instret)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (imem_req !== 1'b0 || halt !== 1'b0 || instret !== 16'd0 ||
        imem_addr !== 7'd0 || instr !== 32'd0) begin
      $display("FAIL reset_state req=%b halt=%b instret=%0d pc=%0d ir=%h need 0",
               imem_req, halt, instret, imem_addr, instr);
      bad++;
    end
    rst = 1'b0;
    cyc();
    run = 1'b1;
    cyc();
    total++;
    if (imem_req !== 1'b1) begin
      $display("FAIL fetch_req got=%b need=1", imem_req);
      bad++;
    end
    run = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 7'd0) begin
      $display("FAIL async_reset req=%b pc=%0d need 0/0", imem_req, imem_addr);
      bad++;
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (imem_req !== 1'b0 || halt !== 1'b0 || instret !== 16'd0) begin
        $display("FAIL idle_hold req=%b halt=%b instret=%0d need 0/0/0",
                 imem_req, halt, instret);
        bad++;
      end
    end
  endtask

  task automatic test_alu();
    run = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    cyc();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 7'd0) begin
      $display("FAIL alu_fetch req=%b addr=%0d need 1/0", imem_req, imem_addr);
      bad++;
    end
    cyc();
    imem_ack = 1'b0;
    total++;
    if (instr !== 32'h0050_0093 || imem_req !== 1'b0 || rf_we !== 1'b0 ||
        addr_mem !== 7'd0) begin
      $display("FAIL alu_exec ir=%h req=%b rf_we=%b am=%0d need 00500093/0/0/0",
               instr, imem_req, rf_we, addr_mem);
      bad++;
    end
    cyc();
    run = 1'b0;
    total++;
    if (rf_we !== 1'b1 || instret !== 16'd0) begin
      $display("FAIL alu_wb rf_we=%b instret=%0d need 1/0", rf_we, instret);
      bad++;
    end
    cyc();
    total++;
    if (rf_we !== 1'b0 || imem_addr !== 7'd1 || instret !== 16'd1 ||
        imem_req !== 1'b0) begin
      $display("FAIL alu_retire rf_we=%b pc=%0d instret=%0d req=%b need 0/1/1/0",
               rf_we, imem_addr, instret, imem_req);
      bad++;
    end
  endtask

  task automatic test_store();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h0010_A023;
    cyc();
    imem_ack = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || addr_mem !== 7'd1) begin
      $display("FAIL st_exec dreq=%b dwe=%b am=%0d need 0/0/1",
               dmem_req, dmem_we, addr_mem);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) dmem_ack = 1'b1;
      total++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || rf_we !== 1'b0) begin
        $display("FAIL st_mem%0d dreq=%b dwe=%b rf_we=%b need 1/1/0",
                 i, dmem_req, dmem_we, rf_we);
        bad++;
      end
    end
    cyc();
    dmem_ack = 1'b0;
    run = 1'b0;
    total++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0) begin
      $display("FAIL st_wb dreq=%b dwe=%b rf_we=%b need 0/0/0",
               dmem_req, dmem_we, rf_we);
      bad++;
    end
    cyc();
    total++;
    if (imem_addr !== 7'd2 || instret !== 16'd2) begin
      $display("FAIL st_retire pc=%0d instret=%0d need 2/2", imem_addr, instret);
      bad++;
    end
  endtask

  task automatic test_branch();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0063;
    cyc();
    imem_ack = 1'b0;
    br_taken = 1'b1;
    br_target = 7'd20;
    cyc();
    br_taken = 1'b0;
    br_target = 7'd0;
    total++;
    if (rf_we !== 1'b0) begin
      $display("FAIL br_wb rf_we=%b need 0", rf_we);
      bad++;
    end
    cyc();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 7'd20 || instret !== 16'd3) begin
      $display("FAIL br_target req=%b pc=%0d instret=%0d need 1/20/3",
               imem_req, imem_addr, instret);
      bad++;
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_006F;
    cyc();
    imem_ack = 1'b0;
    br_taken = 1'b1;
    br_target = 7'd127;
    cyc();
    br_taken = 1'b0;
    br_target = 7'd0;
    total++;
    if (rf_we !== 1'b1) begin
      $display("FAIL jal_wb rf_we=%b need 1", rf_we);
      bad++;
    end
    cyc();
    total++;
    if (imem_addr !== 7'd127) begin
      $display("FAIL jal_target pc=%0d need 127", imem_addr);
      bad++;
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    cyc();
    imem_ack = 1'b0;
    total++;
    if (addr_mem !== 7'd127) begin
      $display("FAIL wrap_am am=%0d need 127", addr_mem);
      bad++;
    end
    cyc();
    run = 1'b0;
    cyc();
    total++;
    if (imem_addr !== 7'd0 || instret !== 16'd5 || imem_req !== 1'b0) begin
      $display("FAIL pc_wrap pc=%0d instret=%0d req=%b need 0/5/0",
               imem_addr, instret, imem_req);
      bad++;
    end
  endtask

  task automatic test_halt();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h0010_0073;
    cyc();
    imem_ack = 1'b0;
    total++;
    if (halt !== 1'b0) begin
      $display("FAIL halt_early halt=%b need 0", halt);
      bad++;
    end
    cyc();
    total++;
    if (halt !== 1'b1 || rf_we !== 1'b0 || instret !== 16'd5) begin
      $display("FAIL halt_enter halt=%b rf_we=%b instret=%0d need 1/0/5",
               halt, rf_we, instret);
      bad++;
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0050_0093;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (halt !== 1'b1 || imem_req !== 1'b0 || rf_we !== 1'b0 ||
          dmem_req !== 1'b0 || instr !== 32'h0010_0073 || instret !== 16'd5) begin
        $display("FAIL halt_hold halt=%b req=%b rf_we=%b dreq=%b ir=%h instret=%0d",
                 halt, imem_req, rf_we, dmem_req, instr, instret);
        bad++;
      end
    end
    imem_ack = 1'b0;
    run = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (halt !== 1'b0 || instret !== 16'd0 || imem_addr !== 7'd0) begin
      $display("FAIL halt_reset halt=%b instret=%0d pc=%0d need 0/0/0",
               halt, instret, imem_addr);
      bad++;
    end
    #2 rst = 1'b0;
    cyc();
  endtask

  task automatic test_run_drop();
    run = 1'b1;
    cyc();
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_A083;
    cyc();
    imem_ack = 1'b0;
    cyc();
    run = 1'b0;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
      $display("FAIL ld_mem dreq=%b dwe=%b need 1/0", dmem_req, dmem_we);
      bad++;
    end
    cyc();
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    total++;
    if (rf_we !== 1'b1 || dmem_req !== 1'b0) begin
      $display("FAIL ld_wb rf_we=%b dreq=%b need 1/0", rf_we, dmem_req);
      bad++;
    end
    cyc();
    total++;
    if (imem_addr !== 7'd1 || instret !== 16'd1 || rf_we !== 1'b0) begin
      $display("FAIL ld_retire pc=%0d instret=%0d rf_we=%b need 1/1/0",
               imem_addr, instret, rf_we);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++;
      if (imem_req !== 1'b0 || imem_addr !== 7'd1) begin
        $display("FAIL ld_idle req=%b pc=%0d need 0/1", imem_req, imem_addr);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_branch();
    test_halt();
    test_run_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
